// File: rtl/ex_stage.sv
// ex_stage: execute stage at the consumer end of the ID/EX register.
// Single-cycle ALU ops retire on the edge after accept. MUL runs a
// shift-add loop for DATA_W cycles and stalls decode through ex_ready.
// Optional build macro EX_OVF_EN adds a registered signed-overflow flag
// (ovf) for ADD/SUB.
//
// Handshake: an instruction is accepted on a rising edge where
// id_valid & ex_ready & !flush. ex_ready is combinational (state==IDLE).
// Decode must hold its instruction stable while ex_ready is low.
// wb_valid is a one-cycle pulse per retiring instruction.
module ex_stage #(
  parameter int DATA_W = 8,
  parameter int RD_W   = 5,
  parameter int SH_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              id_valid,
  output logic              ex_ready,
  input  logic [2:0]        alu_sig,
  input  logic              wb_en,
  input  logic [DATA_W-1:0] r1,
  input  logic [DATA_W-1:0] r2,
  input  logic [RD_W-1:0]   rd,
`ifdef EX_OVF_EN
  output logic              ovf,
`endif
  output logic              wb_valid,
  output logic              wb_we,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_W-1:0]   wb_rd
);

  localparam int CNT_W = SH_W + 1;
  localparam int MSB   = DATA_W - 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [RD_W-1:0]     mrd_q, mrd_d;
  logic                mwe_q, mwe_d;
  logic                wb_valid_q, wb_valid_d;
  logic                wb_we_q, wb_we_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [RD_W-1:0]     wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]   alu_res;
  logic [DATA_W-1:0]   mul_step;

  assign ex_ready = (state_q == IDLE);
  assign wb_valid = wb_valid_q;
  assign wb_we    = wb_we_q;
  assign wb_data  = wb_data_q;
  assign wb_rd    = wb_rd_q;

  // Single-cycle ALU result for the instruction presented by decode.
  always_comb begin
    alu_res = '0;
    case (alu_sig)
      OP_ADD:  alu_res = r1 + r2;
      OP_SUB:  alu_res = r1 - r2;
      OP_AND:  alu_res = r1 & r2;
      OP_OR:   alu_res = r1 | r2;
      OP_XOR:  alu_res = r1 ^ r2;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(r1) < $signed(r2))};
      OP_MUL:  alu_res = '0;
      OP_SHL:  alu_res = r1 << r2[SH_W-1:0];
      default: alu_res = '0;
    endcase
  end

`ifdef EX_OVF_EN
  logic alu_ovf;
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;

  // Signed overflow: ADD with like-signed operands, SUB with unlike-signed
  // operands, and the result sign differs from r1.
  always_comb begin
    alu_ovf = 1'b0;
    if (alu_sig == OP_ADD)
      alu_ovf = (r1[MSB] == r2[MSB]) && (alu_res[MSB] != r1[MSB]);
    else if (alu_sig == OP_SUB)
      alu_ovf = (r1[MSB] != r2[MSB]) && (alu_res[MSB] != r1[MSB]);
  end
`endif

  // Shift-add step: add the multiplicand when the multiplier LSB is set.
  assign mul_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Next-state and retirement logic; flush overrides everything.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    mrd_d      = mrd_q;
    mwe_d      = mwe_q;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
`ifdef EX_OVF_EN
    ovf_d      = ovf_q;
`endif
    if (flush) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (id_valid) begin
            if (alu_sig == OP_MUL) begin
              state_d  = BUSY;
              mcand_d  = r1;
              mplier_d = r2;
              acc_d    = '0;
              count_d  = CNT_W'(DATA_W);
              mrd_d    = rd;
              mwe_d    = wb_en;
            end else begin
              wb_valid_d = 1'b1;
              wb_data_d  = alu_res;
              wb_rd_d    = rd;
              wb_we_d    = wb_en && (rd != '0);
`ifdef EX_OVF_EN
              ovf_d      = alu_ovf;
`endif
            end
          end
        end
        BUSY: begin
          acc_d    = mul_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wb_data_d  = mul_step;
            wb_rd_d    = mrd_q;
            wb_we_d    = mwe_q && (mrd_q != '0);
`ifdef EX_OVF_EN
            ovf_d      = 1'b0;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      mrd_q      <= '0;
      mwe_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
`ifdef EX_OVF_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      mrd_q      <= mrd_d;
      mwe_q      <= mwe_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
`ifdef EX_OVF_EN
      ovf_q      <= ovf_d;
`endif
    end
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage: consumer end of the ID/EX register.
- Takes the decoded ALU select, write-back enable, two operands and destination register from ID/EX.
- Computes the result: single-cycle ALU ops, plus a multi-cycle shift-add multiply that stalls decode.
- Registers the result into the EX/WB interface read by the register-file write port.

Parameters:
DATA_W, 8, operand/result width
RD_W, 5, destination register index width
SH_W, 3, shift-amount bits taken from r2 (log2 DATA_W)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush
id_valid  in  1  ID/EX holds a valid instruction
ex_ready  out  1  stage can accept this cycle (combinational: state==IDLE)
alu_sig  in  3  operation select
wb_en  in  1  instruction writes the register file
r1  in  DATA_W  operand A
r2  in  DATA_W  operand B
rd  in  RD_W  destination register index
wb_valid  out  1  one-cycle pulse: an instruction retires from EX
wb_we  out  1  register-file write enable
wb_data  out  DATA_W  result
wb_rd  out  RD_W  destination index

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, count=0, internal multiply registers=0.
  - wb_valid=0, wb_we=0, wb_data=0, wb_rd=0, ovf=0 when present.
- Accept: id_valid & ex_ready & !flush at a rising edge.
- alu_sig encoding:
  - 000 ADD: r1+r2 mod 2^DATA_W
  - 001 SUB: r1-r2 mod 2^DATA_W
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT: 1 if signed r1<r2, else 0; zero-extended
  - 110 MUL: low DATA_W bits of r1*r2; multi-cycle
  - 111 SHL: r1 << r2[SH_W-1:0]
- Single-cycle ops:
  - Accepted at edge N. After edge N: wb_valid=1, wb_data=result, wb_rd=rd, wb_we=wb_en & (rd!=0).
  - Back-to-back accepts give consecutive wb_valid pulses.
- wb_valid is a one-cycle pulse. It is 0 after any edge that neither accepts a single-cycle op nor completes a MUL.
- Writes to register 0 are suppressed: wb_we=0. wb_valid and wb_data still update.
- MUL FSM:
  - IDLE -> BUSY on accept with alu_sig=110. Latch multiplicand=r1, multiplier=r2, acc=0, count=DATA_W, rd, wb_en. No wb_valid at the accept edge.
  - BUSY: on each edge, if multiplier[0] then acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count -= 1.
  - On the edge where count goes 1->0: load wb_data with the new acc, assert wb_valid, set wb_we per the rule above, state -> IDLE.
  - Result is therefore valid DATA_W edges after accept (8 for default).
  - ex_ready=0 for the whole of BUSY. id_valid is ignored while BUSY; decode must hold its instruction.
  - Multiplier of 0 still takes the full DATA_W cycles; fixed latency.
- flush:
  - On any edge with flush=1: state -> IDLE, count=0, wb_valid=0, wb_we=0. Any in-flight MUL is discarded.
  - flush together with id_valid: flush wins and the instruction is dropped.
  - wb_data and wb_rd hold their previous values.
- Reset mid-MUL: immediate return to IDLE, all outputs cleared; no wb_valid from the aborted op.
- Outputs change only on clk edges or reset. ex_ready is the only combinational output.

Optional Feature:
- Macro EX_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), reset 0, registered alongside wb_valid.
  - ovf=1 on ADD or SUB when the signed result overflows (operand signs and result sign disagree per the add/sub rule).
  - ovf=0 for all other ops, including MUL.
  - ovf is not cleared by flush; it updates only with retiring instructions.
- Undefined: no ovf port and no overflow logic. All other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-sim -> all outputs 0 immediately, ex_ready=1.
- ALU sweep with r1=8'hF0, r2=8'h13, rd=5, wb_en=1, one op per cycle:
  - ADD=8'h03, SUB=8'hDD, AND=8'h10, OR=8'hF3, XOR=8'hE3, SLT=8'h01, SHL(r2[2:0]=3)=8'h80.
  - Each result appears one cycle after accept with wb_we=1 and wb_rd=5.
- MUL: r1=8'd13, r2=8'd11, rd=7 -> ex_ready=0 for 8 cycles; wb_valid pulses once 8 edges after accept with wb_data=8'h8F (143).
  - A held ADD is accepted on the first cycle ex_ready=1 and retires on the next edge.
- rd=0 with wb_en=1, ADD 8'h01+8'h01 -> wb_valid=1, wb_data=8'h02, wb_we=0.
- flush: assert flush 3 cycles into MUL 8'hFF*8'hFF -> no wb_valid ever for that MUL; ex_ready=1 the next cycle.
  - flush with id_valid on ADD -> no retirement.
- EX_OVF_EN defined:
  - ADD 8'h7F+8'h01 -> wb_data=8'h80, ovf=1.
  - SUB 8'h80-8'h01 -> wb_data=8'h7F, ovf=1.
  - ADD 8'h01+8'h01 -> ovf=0.
